// File: rtl/out_uart_pkg.sv
// Shared types and frame constants for the byte-stream UART transmitter.
package out_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;
endpackage

// File: rtl/out_fifo.sv
// Synchronous valid/ready byte FIFO with occupancy count; storage is unreset.
module out_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [W-1:0]  wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  // Full blocks writes regardless of a concurrent read.
  assign wr_ready = reset && (count != CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_ready && rd_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/out_uart_tx.sv
// 8N1 UART transmitter fed from a byte FIFO; back-to-back frames, enable gates new starts.
module out_uart_tx
  import out_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam int          BCW      = $clog2(DATA_BITS);

  tx_state_e              state;
  logic [15:0]            baud;
  logic [BCW-1:0]         bitcnt;
  logic [DATA_BITS-1:0]   shifter;
  logic                   fifo_wr_ready, fifo_rd_valid, pop;
  logic [7:0]             fifo_rd_data;

  out_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (in_valid && enable),
    .wr_ready (fifo_wr_ready),
    .wr_data  (in_data),
    .rd_valid (fifo_rd_valid),
    .rd_ready (pop),
    .rd_data  (fifo_rd_data),
    .count    (fifo_count)
  );

  assign in_ready = enable && fifo_wr_ready;
  // A new frame may start from IDLE or straight out of the last stop-bit cycle.
  assign pop  = fifo_rd_valid && enable &&
                ((state == IDLE) || (state == STOP && baud == '0));
  assign busy = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      baud    <= '0;
      bitcnt  <= '0;
      shifter <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            state   <= START;
            txd     <= 1'b0;
            shifter <= fifo_rd_data;
            baud    <= BAUD_MAX;
          end
        end
        START: begin
          if (baud == '0) begin
            state   <= DATA;
            txd     <= shifter[0];
            shifter <= shifter >> 1;
            baud    <= BAUD_MAX;
            bitcnt  <= '0;
          end else baud <= baud - 1'b1;
        end
        DATA: begin
          if (baud == '0) begin
            baud <= BAUD_MAX;
            if (bitcnt == BCW'(DATA_BITS - 1)) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              txd     <= shifter[0];
              shifter <= shifter >> 1;
              bitcnt  <= bitcnt + 1'b1;
            end
          end else baud <= baud - 1'b1;
        end
        STOP: begin
          if (baud == '0) begin
            if (pop) begin
              state   <= START;
              txd     <= 1'b0;
              shifter <= fifo_rd_data;
              baud    <= BAUD_MAX;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else baud <= baud - 1'b1;
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: directed scenarios plus random traffic against a frame-timeline model.
module tb_out_uart_tx;
  localparam int CLKS  = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CLKS;

  logic       clk = 1'b0;
  logic       reset, enable, in_valid, in_ready, txd, busy;
  logic [7:0] in_data;
  logic [3:0] fifo_count;

  out_uart_tx #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference: queue of bytes plus position inside the frame being sent.
  logic [7:0] q[$];
  logic [7:0] cur;
  bit         active = 0;
  int         pos = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic exp_txd();
    int b;
    if (!active) return 1'b1;
    b = pos / CLKS;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  task automatic step(input logic r, input logic e, input logic v,
                      input logic [7:0] d, output logic acc);
    reset = r; enable = e; in_valid = v; in_data = d;
    #1;
    acc = r && e && (q.size() < DEPTH);
    chk("in_ready", in_ready, acc);
    @(posedge clk);
    if (!r) begin
      q.delete();
      active = 0;
      pos = 0;
    end else begin
      if (active) begin
        pos++;
        if (pos == FRAME) active = 0;
      end
      if (!active && q.size() > 0 && e) begin
        cur = q.pop_front();
        active = 1;
        pos = 0;
      end
      if (v && acc) q.push_back(d);
    end
    @(negedge clk);
    chk("txd", txd, exp_txd());
    chk("busy", busy, active || (q.size() != 0));
    chk("fifo_count", fifo_count, q.size());
  endtask

  task automatic idle(input int n, input logic e);
    logic a;
    for (int i = 0; i < n; i++) step(1'b1, e, 1'b0, 8'h00, a);
  endtask

  initial begin
    logic a;
    int   idx;
    logic r, e, v;
    reset = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    step(1'b0, 1'b1, 1'b1, 8'hFF, a);
    step(1'b0, 1'b1, 1'b0, 8'h00, a);

    // Single byte 0xA5 framed after reset.
    step(1'b1, 1'b1, 1'b1, 8'hA5, a);
    chk("a5_accept", a, 1'b1);
    idle(45, 1'b1);

    // Hold in_valid on an incrementing byte stream; fills the FIFO.
    idx = 0;
    for (int c = 0; c < 420; c++) begin
      step(1'b1, 1'b1, idx < 16, 8'(idx), a);
      if (idx < 16 && a) idx++;
    end
    chk("stream_all_taken", idx, 16);
    idle(FRAME * 8, 1'b1);

    // Enable drop mid-frame with three bytes queued.
    step(1'b1, 1'b1, 1'b1, 8'h3C, a);
    step(1'b1, 1'b1, 1'b1, 8'hC3, a);
    step(1'b1, 1'b1, 1'b1, 8'h81, a);
    idle(10, 1'b1);
    idle(70, 1'b0);
    chk("hold_count", fifo_count, 2);
    idle(100, 1'b1);

    // Reset pulse during DATA with bytes queued.
    step(1'b1, 1'b1, 1'b1, 8'h11, a);
    step(1'b1, 1'b1, 1'b1, 8'h22, a);
    step(1'b1, 1'b1, 1'b1, 8'h33, a);
    idle(12, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, a);
    chk("rst_txd", txd, 1'b1);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 1'b0);
    idle(60, 1'b1);

    // Random traffic with occasional enable drops and resets.
    e = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      r = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 49) == 0) e = ~e;
      v = ($urandom_range(0, 3) != 0);
      step(r, e, v, 8'($urandom), a);
    end
    idle(FRAME * (DEPTH + 2), 1'b1);
    chk("drained_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/out_uart_tx.md
OUT_UART_TX -- requirements
Module: out_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, byte buffer depth (power of two, 2..64).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port enable  input  1  global enable from the core; 0 = no accept and no new frame start.
REQ-006 SHALL have port in_data  input  8  byte from the core's out port.
REQ-007 SHALL have port in_valid  input  1  in_data holds a byte to transmit.
REQ-008 SHALL have port in_ready  output  1  the block accepts in_data this cycle.
REQ-009 SHALL have port txd  output  1  UART serial line, 8N1, idle high, registered.
REQ-010 SHALL have port busy  output  1  a frame is in progress or the FIFO is non-empty.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes buffered.

Function
REQ-012 The FIFO SHALL hold up to FIFO_DEPTH bytes; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-013 in_ready SHALL be 1 iff reset=1, enable=1 and fifo_count<FIFO_DEPTH.
REQ-014 A push SHALL occur on each edge where in_valid=1 and in_ready=1.
REQ-015 When the FIFO is full, in_ready SHALL stay 0 even if a pop occurs in the same cycle.
REQ-016 A simultaneous push and pop on a non-full FIFO SHALL leave fifo_count unchanged.
REQ-017 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-018 IDLE -> START (pop, load shifter, txd<=0) on the edge where fifo_count>0 and enable=1.
REQ-019 START -> DATA after CLKS_PER_BIT cycles.
REQ-020 DATA SHALL shift out 8 bits LSB first, CLKS_PER_BIT cycles each, then go to STOP.
REQ-021 STOP SHALL drive txd=1 for CLKS_PER_BIT cycles.
REQ-022 At the end of STOP, the FSM SHALL go directly to START (pop) if fifo_count>0 and enable=1, else to IDLE, with no extra idle cycle.
REQ-023 A byte pushed at edge N into an empty FIFO with the FSM in IDLE SHALL make txd fall at edge N+1.
REQ-024 A frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-025 Deasserting enable mid-frame SHALL let the current frame complete.
REQ-026 After such a frame, the FSM SHALL return to IDLE with buffered bytes retained; transmission SHALL resume when enable=1.
REQ-027 The baud counter SHALL load CLKS_PER_BIT-1 at each bit start and decrement to 0.
REQ-028 busy SHALL be (state!=IDLE) or (fifo_count!=0).

Reset
REQ-029 While reset=0 at an edge: state<=IDLE, txd<=1, fifo_count<=0, both pointers<=0, baud and bit counters<=0, and busy SHALL read 0 afterwards.
REQ-030 While reset=0, in_ready SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame (txd=1 after that edge) and discard all FIFO contents.
REQ-032 FIFO storage SHALL need no reset.

Structure
REQ-033 Package out_uart_pkg SHALL hold the FSM state enum typedef and the constants DATA_BITS=8 and FRAME_BITS=10.
REQ-034 The FIFO SHALL be a sub-module out_fifo (sync, valid/ready, count output) instantiated once.
REQ-035 FSM, baud counter and shifter SHALL reside in out_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-036 Push 0xA5 after reset -> txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; txd falls 1 cycle after the accept; busy=0 after cycle 41.
REQ-037 in_valid held with bytes 0x00..0x0F -> 9 bytes accepted, then in_ready=0 with fifo_count=8; 9 frames back-to-back over 360 cycles, with no high gap beyond each stop bit.
REQ-038 Full FIFO, pop occurring, in_valid=1 -> in_ready=0, byte not taken, fifo_count=7 next cycle.
REQ-039 enable=0 during DATA of the 1st of 3 queued bytes -> frame ends normally, txd stays 1, fifo_count=2; enable=1 -> txd falls 1 cycle later.
REQ-040 reset=0 for 1 cycle during DATA with 3 bytes queued -> txd=1, fifo_count=0, busy=0 next cycle; nothing further transmitted.
